// File: rtl/ws2812_line_decoder.sv
// WS2812 serial line decoder: measures high-pulse widths on the synchronized line and assembles GRB pixels.
// Define WS2812_DECODER_STATS_EN to build the saturating frame_count/err_count statistics counters.
module ws2812_line_decoder #(
    parameter int MAX_POS           = 109,
    parameter int BIT_THRESHOLD_CLK = 30,
    parameter int MIN_HIGH_CLK      = 8,
    parameter int MAX_HIGH_CLK      = 50,
    parameter int RESET_CLK_CNT     = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        leds_line,
    output logic        pixel_valid,
    output logic [23:0] pixel_grb,
    output logic [6:0]  pixel_index,
    output logic        frame_done,
    output logic [7:0]  frame_pixels,
    output logic        err,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);
    // state  | meaning
    // RESYNC | line not trusted; waiting for a full reset-length low period
    // IDLE   | between frames, line low, waiting for the first high of a frame
    // HIGH   | measuring a high pulse to classify the bit
    // LOW    | measuring the low gap; a long enough gap ends the frame
    localparam logic [1:0] S_RESYNC = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] S_LOW    = 2'd3;

    localparam int HW = $clog2(MAX_HIGH_CLK + 1);
    localparam int LW = $clog2(RESET_CLK_CNT + 1);
    localparam int PW = $clog2(MAX_POS + 2);

    localparam logic [HW-1:0] HIGH_MIN  = HW'(MIN_HIGH_CLK);
    localparam logic [HW-1:0] HIGH_THR  = HW'(BIT_THRESHOLD_CLK);
    localparam logic [HW-1:0] HIGH_LAST = HW'(MAX_HIGH_CLK - 1);
    localparam logic [LW-1:0] LOW_LAST  = LW'(RESET_CLK_CNT - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(MAX_POS);

    logic [1:0]    sync_q;
    logic          line_s;
    logic [1:0]    state_q, state_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [HW-1:0] high_cnt_q, high_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [22:0]   shift_q, shift_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [23:0]   pixel_grb_q, pixel_grb_d;
    logic [6:0]    pixel_index_q, pixel_index_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_pixels_q, frame_pixels_d;
    logic          err_q, err_d;
    logic          bit_val;

    assign line_s = sync_q[1];

    always_comb begin
        state_d        = state_q;
        low_cnt_d      = low_cnt_q;
        high_cnt_d     = high_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        pix_cnt_d      = pix_cnt_q;
        pixel_valid_d  = 1'b0;
        pixel_grb_d    = pixel_grb_q;
        pixel_index_d  = pixel_index_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        err_d          = 1'b0;
        bit_val        = 1'b0;

        case (state_q)
            S_RESYNC: begin
                if (line_s) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LOW_LAST) begin
                    low_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + LW'(1);
                end
            end

            S_IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
                pix_cnt_d = '0;
                if (line_s) begin
                    high_cnt_d = HW'(1);
                    state_d    = S_HIGH;
                end
            end

            S_HIGH: begin
                if (line_s) begin
                    if (high_cnt_q == HIGH_LAST) begin
                        err_d     = 1'b1;
                        low_cnt_d = '0;
                        state_d   = S_RESYNC;
                    end else begin
                        high_cnt_d = high_cnt_q + HW'(1);
                    end
                end else if (high_cnt_q < HIGH_MIN) begin
                    err_d     = 1'b1;
                    low_cnt_d = '0;
                    state_d   = S_RESYNC;
                end else begin
                    bit_val   = (high_cnt_q >= HIGH_THR);
                    low_cnt_d = LW'(1);
                    state_d   = S_LOW;
                    // Pixels past the end of the strip are consumed but never strobed.
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        if (pix_cnt_q <= POS_LAST) begin
                            pixel_valid_d = 1'b1;
                            pixel_grb_d   = {shift_q, bit_val};
                            pixel_index_d = 7'(pix_cnt_q);
                            pix_cnt_d     = pix_cnt_q + PW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        shift_d   = {shift_q[21:0], bit_val};
                    end
                end
            end

            default: begin
                if (line_s) begin
                    high_cnt_d = HW'(1);
                    state_d    = S_HIGH;
                end else if (low_cnt_q == LOW_LAST) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = 8'(pix_cnt_q);
                    err_d          = (bit_cnt_q != 5'd0);
                    low_cnt_d      = '0;
                    state_d        = S_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + LW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q         <= 2'b00;
            state_q        <= S_RESYNC;
            low_cnt_q      <= '0;
            high_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            pix_cnt_q      <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_grb_q    <= '0;
            pixel_index_q  <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            err_q          <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], leds_line};
            state_q        <= state_d;
            low_cnt_q      <= low_cnt_d;
            high_cnt_q     <= high_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            pix_cnt_q      <= pix_cnt_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_grb_q    <= pixel_grb_d;
            pixel_index_q  <= pixel_index_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            err_q          <= err_d;
        end
    end

    assign pixel_valid  = pixel_valid_q;
    assign pixel_grb    = pixel_grb_q;
    assign pixel_index  = pixel_index_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign err          = err_q;

`ifdef WS2812_DECODER_STATS_EN
    logic [15:0] frame_count_q;
    logic [7:0]  err_count_q;

    // Counted from the next-state strobes so the totals line up with the strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            if (frame_done_d && (frame_count_q != 16'hFFFF)) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (err_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`else
    assign frame_count = 16'd0;
    assign err_count   = 8'd0;
`endif

endmodule

// File: tb/tb_ws2812_line_decoder.sv
// Directed bench for ws2812_line_decoder: a default-timing instance plus a short-timing
// instance used for the long full-strip frames.
module tb_ws2812_line_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        leds_line;
    logic        line_f;

    logic        pixel_valid, frame_done, err;
    logic [23:0] pixel_grb;
    logic [6:0]  pixel_index;
    logic [7:0]  frame_pixels, err_count;
    logic [15:0] frame_count;

    logic        pixel_valid_f, frame_done_f, err_f;
    logic [23:0] pixel_grb_f;
    logic [6:0]  pixel_index_f;
    logic [7:0]  frame_pixels_f, err_count_f;
    logic [15:0] frame_count_f;

`ifdef WS2812_DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #10 clk = ~clk;

    ws2812_line_decoder dut (
        .clk(clk), .rst_n(rst_n), .leds_line(leds_line),
        .pixel_valid(pixel_valid), .pixel_grb(pixel_grb), .pixel_index(pixel_index),
        .frame_done(frame_done), .frame_pixels(frame_pixels), .err(err),
        .frame_count(frame_count), .err_count(err_count)
    );

    ws2812_line_decoder #(
        .MAX_POS(109), .BIT_THRESHOLD_CLK(4), .MIN_HIGH_CLK(2),
        .MAX_HIGH_CLK(8), .RESET_CLK_CNT(32)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .leds_line(line_f),
        .pixel_valid(pixel_valid_f), .pixel_grb(pixel_grb_f), .pixel_index(pixel_index_f),
        .frame_done(frame_done_f), .frame_pixels(frame_pixels_f), .err(err_f),
        .frame_count(frame_count_f), .err_count(err_count_f)
    );

    int n_checks = 0;
    int n_err    = 0;

    int   pv_cnt = 0, fd_cnt = 0, err_seen = 0;
    logic fd_err_last = 1'b0;
    logic [23:0] log_grb [256];
    logic [6:0]  log_idx [256];

    int pvf_cnt = 0, fdf_cnt = 0, errf_seen = 0;
    logic [23:0] logf_grb [256];
    logic [6:0]  logf_idx [256];

    // Strobe recorder: captures every pulse so the directed sequence can check counts and data.
    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            if (pv_cnt < 256) begin
                log_grb[pv_cnt] = pixel_grb;
                log_idx[pv_cnt] = pixel_index;
            end
            pv_cnt++;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_err_last = err;
        end
        if (err === 1'b1) err_seen++;
        if (pixel_valid_f === 1'b1) begin
            if (pvf_cnt < 256) begin
                logf_grb[pvf_cnt] = pixel_grb_f;
                logf_idx[pvf_cnt] = pixel_index_f;
            end
            pvf_cnt++;
        end
        if (frame_done_f === 1'b1) fdf_cnt++;
        if (err_f === 1'b1) errf_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit f, input logic v);
        if (f) line_f = v;
        else   leds_line = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit f, input int h, input int l);
        drive(f, 1'b1);
        idle(h);
        drive(f, 1'b0);
        idle(l);
    endtask

    task automatic send_pix(input bit f, input int h1, input int l1, input int h0, input int l0,
                            input logic [23:0] v);
        for (int i = 23; i >= 0; i--) begin
            if (v[i]) pulse(f, h1, l1);
            else      pulse(f, h0, l0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pixel_valid"},  {31'd0, pixel_valid}, 32'd0);
        chk({tag, "_pixel_grb"},    {8'd0, pixel_grb},     32'd0);
        chk({tag, "_pixel_index"},  {25'd0, pixel_index},  32'd0);
        chk({tag, "_frame_done"},   {31'd0, frame_done},   32'd0);
        chk({tag, "_frame_pixels"}, {24'd0, frame_pixels}, 32'd0);
        chk({tag, "_err"},          {31'd0, err},          32'd0);
        chk({tag, "_frame_count"},  {16'd0, frame_count},  32'd0);
        chk({tag, "_err_count"},    {24'd0, err_count},    32'd0);
    endtask

    initial begin
        int base, e0, fd0, snap;
        rst_n = 1'b0;
        leds_line = 1'b0;
        line_f = 1'b0;
        idle(3);
        chk_zero("in_reset");
        rst_n = 1'b1;
        idle(2510);
        chk("resync_no_frame_done", fd_cnt, 0);
        chk("resync_no_err", err_seen, 0);

        // Full strip of 110 pixels, grb = index (short-timing instance)
        base = pvf_cnt;
        for (int p = 0; p < 110; p++) send_pix(1'b1, 4, 1, 2, 1, 24'(p));
        idle(40);
        chk("f110_strobes", pvf_cnt - base, 110);
        for (int p = 0; p < 110; p++) begin
            chk("f110_idx", {25'd0, logf_idx[base + p]}, p);
            chk("f110_grb", {8'd0, logf_grb[base + p]}, p);
        end
        chk("f110_frame_pixels", {24'd0, frame_pixels_f}, 110);
        chk("f110_frame_done", fdf_cnt, 1);
        chk("f110_no_err", errf_seen, 0);

        // 112 pixels: the two past the end are dropped
        base = pvf_cnt;
        for (int p = 0; p < 112; p++) send_pix(1'b1, 4, 1, 2, 1, 24'(p));
        idle(40);
        chk("f112_strobes", pvf_cnt - base, 110);
        for (int p = 0; p < 110; p++) begin
            chk("f112_idx", {25'd0, logf_idx[base + p]}, p);
            chk("f112_grb", {8'd0, logf_grb[base + p]}, p);
        end
        chk("f112_frame_pixels", {24'd0, frame_pixels_f}, 110);
        chk("f112_index_hold", {25'd0, pixel_index_f}, 109);
        chk("f112_grb_hold", {8'd0, pixel_grb_f}, 109);
        chk("f112_frame_done", fdf_cnt, 2);
        chk("f112_no_err", errf_seen, 0);

        // Single pixel 0xFF0000 with nominal timing
        base = pv_cnt;
        send_pix(1'b0, 40, 22, 20, 42, 24'hFF0000);
        idle(2510);
        chk("one_px_strobes", pv_cnt - base, 1);
        chk("one_px_grb", {8'd0, log_grb[base]}, 32'hFF0000);
        chk("one_px_idx", {25'd0, log_idx[base]}, 0);
        chk("one_px_frame_done", fd_cnt, 1);
        chk("one_px_frame_pixels", {24'd0, frame_pixels}, 1);
        chk("one_px_grb_hold", {8'd0, pixel_grb}, 32'hFF0000);
        chk("one_px_no_err", err_seen, 0);
        chk("one_px_frame_count", {16'd0, frame_count}, STATS ? 32'd1 : 32'd0);

        // Pulse-width boundaries: 30H=1, 8H=0, 29H=0, 49H=1 without a stuck error
        base = pv_cnt;
        send_pix(1'b0, 30, 1, 8, 1, 24'h00A5FF);
        send_pix(1'b0, 29, 1, 29, 1, 24'hFFFFFF);
        send_pix(1'b0, 49, 1, 49, 1, 24'hFFFFFF);
        idle(2510);
        chk("bnd_strobes", pv_cnt - base, 3);
        chk("bnd_grb0", {8'd0, log_grb[base]}, 32'h00A5FF);
        chk("bnd_grb1", {8'd0, log_grb[base + 1]}, 32'h000000);
        chk("bnd_grb2", {8'd0, log_grb[base + 2]}, 32'hFFFFFF);
        chk("bnd_idx2", {25'd0, log_idx[base + 2]}, 2);
        chk("bnd_frame_pixels", {24'd0, frame_pixels}, 3);
        chk("bnd_no_err", err_seen, 0);

        // Glitch mid-pixel, then stuck-high, then a clean frame
        base = pv_cnt;
        e0   = err_seen;
        fd0  = fd_cnt;
        for (int i = 0; i < 5; i++) pulse(1'b0, 30, 1);
        pulse(1'b0, 5, 1);
        idle(2510);
        chk("glitch_err", err_seen - e0, 1);
        chk("glitch_no_pv", pv_cnt - base, 0);
        chk("glitch_no_fd", fd_cnt - fd0, 0);
        pulse(1'b0, 60, 2510);
        chk("stuck_err", err_seen - e0, 2);
        chk("stuck_no_fd", fd_cnt - fd0, 0);
        send_pix(1'b0, 30, 1, 8, 1, 24'h123456);
        idle(2510);
        chk("recover_pv", pv_cnt - base, 1);
        chk("recover_grb", {8'd0, log_grb[base]}, 32'h123456);
        chk("recover_idx", {25'd0, log_idx[base]}, 0);
        chk("recover_frame_pixels", {24'd0, frame_pixels}, 1);
        chk("recover_no_new_err", err_seen - e0, 2);

        // Reset during bit 10 of pixel 3
        base = pv_cnt;
        fd0  = fd_cnt;
        for (int p = 1; p <= 3; p++) send_pix(1'b0, 30, 1, 8, 1, 24'(p));
        for (int i = 0; i < 10; i++) pulse(1'b0, 8, 1);
        drive(1'b0, 1'b1);
        idle(4);
        chk("mid_pre_reset_pv", pv_cnt - base, 3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk_zero("mid_reset");
        idle(4);
        drive(1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 13; i++) pulse(1'b0, 30, 1);
        send_pix(1'b0, 30, 1, 8, 1, 24'h0F0F0F);
        snap = pv_cnt;
        idle(2510);
        chk("mid_no_strobe", pv_cnt - base, 3);
        chk("mid_no_strobe_after", pv_cnt, snap);
        chk("mid_no_frame_done", fd_cnt - fd0, 0);

        // 12 bits then reset-length low: partial pixel
        base = pv_cnt;
        e0   = err_seen;
        fd0  = fd_cnt;
        for (int i = 0; i < 12; i++) pulse(1'b0, (i % 2 == 0) ? 30 : 8, 1);
        idle(2510);
        chk("partial_fd", fd_cnt - fd0, 1);
        chk("partial_err_same_cycle", {31'd0, fd_err_last}, 1);
        chk("partial_err", err_seen - e0, 1);
        chk("partial_no_pv", pv_cnt - base, 0);
        chk("partial_frame_pixels", {24'd0, frame_pixels}, 0);
        chk("partial_frame_count", {16'd0, frame_count}, STATS ? 32'd1 : 32'd0);
        chk("partial_err_count", {24'd0, err_count}, STATS ? 32'd1 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/ws2812_line_decoder.md
WS2812_LINE_DECODER -- requirements
Module: ws2812_line_decoder

Interface
REQ-001 Parameter MAX_POS, default 109: index of the last pixel on the strip; a frame holds MAX_POS+1 pixels.
REQ-002 Parameter BIT_THRESHOLD_CLK, default 30: high-pulse length in clk cycles at or above which a bit decodes as 1.
REQ-003 Parameter MIN_HIGH_CLK, default 8: high pulses shorter than this are glitch errors.
REQ-004 Parameter MAX_HIGH_CLK, default 50: a high level lasting this many cycles is a stuck-high error.
REQ-005 Parameter RESET_CLK_CNT, default 2500: continuous low cycles that mark a frame end (50 us at 50 MHz).
REQ-006 clk  input  1  system clock, 50 MHz nominal, all logic on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 leds_line  input  1  asynchronous WS2812 serial line being decoded.
REQ-009 pixel_valid  output  1  one-cycle strobe: pixel_grb and pixel_index are valid.
REQ-010 pixel_grb  output  24  decoded pixel, G[23:16] R[15:8] B[7:0], first-received bit in bit 23.
REQ-011 pixel_index  output  7  position of the decoded pixel, 0 = first after frame start.
REQ-012 frame_done  output  1  one-cycle strobe at each detected frame end.
REQ-013 frame_pixels  output  8  number of complete pixels in the last finished frame, saturating at MAX_POS+1.
REQ-014 err  output  1  one-cycle strobe on any decode error.
REQ-015 frame_count  output  16  frames completed (see Configuration).
REQ-016 err_count  output  8  errors seen (see Configuration).

Function
REQ-017 leds_line SHALL pass a 2-flop synchronizer; all timing counts use the synchronized signal (2-cycle input latency).
REQ-018 FSM states SHALL be RESYNC, IDLE, HIGH, LOW.
REQ-019 RESYNC: count low cycles, clear the count on any high level, and go to IDLE when the count reaches RESET_CLK_CNT; frame_done SHALL NOT fire on this transition.
REQ-020 IDLE: clear the bit counter, shift register and pixel index; on a rising edge, go to HIGH with the high count = 1.
REQ-021 HIGH: increment the high count each cycle while high.
REQ-022 HIGH, on a falling edge: count < MIN_HIGH_CLK -> err, RESYNC; count >= BIT_THRESHOLD_CLK -> shift in 1, otherwise shift in 0; then go to LOW with the low count = 1.
REQ-023 HIGH: the count reaching MAX_HIGH_CLK while still high -> err, RESYNC.
REQ-024 On the 24th bit, pixel_valid SHALL assert the next cycle with the assembled pixel_grb and the current pixel_index; then pixel_index increments and the bit counter clears.
REQ-025 Pixels with index > MAX_POS SHALL NOT strobe pixel_valid; pixel_index SHALL saturate at MAX_POS+1.
REQ-026 LOW: a rising edge -> HIGH with the high count = 1.
REQ-027 LOW: the low count reaching RESET_CLK_CNT -> frame_done pulse, frame_pixels updated, go to IDLE.
REQ-028 LOW, frame end with a nonzero bit counter (partial pixel): err SHALL pulse in the same cycle as frame_done; the partial pixel is discarded.
REQ-029 pixel_grb and frame_pixels SHALL hold their values between strobes.
REQ-030 All counters SHALL be sized so they never wrap below their terminal values.

Reset
REQ-031 rst_n low at a clock edge SHALL force state RESYNC, clear the synchronizer, and clear all counters and the shift register.
REQ-032 During and after reset, outputs SHALL be 0: pixel_valid, pixel_grb, pixel_index, frame_done, frame_pixels, err, frame_count, err_count.
REQ-033 Reset mid-frame SHALL discard partial data; decoding restarts only after a full RESET_CLK_CNT low period.

Configuration
REQ-034 Macro WS2812_DECODER_STATS_EN defined: frame_count SHALL increment on each frame_done and err_count on each err, both saturating at all-ones.
REQ-035 Macro WS2812_DECODER_STATS_EN undefined: frame_count and err_count SHALL be constant 0 and no counter logic is synthesized.

Verification
REQ-036 Scenario: reset, 2500 low cycles, one pixel 0xFF0000 (1 = 40H/22L, 0 = 20H/42L), then 2500 low -> pixel_valid once with grb=0xFF0000, index=0; frame_done; frame_pixels=1.
REQ-037 Scenario: 110 pixels with grb = index -> 110 strobes with matching index and data; frame_pixels=110.
REQ-038 Scenario: 112 pixels -> strobes only for indices 0..109; frame_pixels=110.
REQ-039 Scenario: 5-cycle high pulse mid-pixel -> err strobe, no pixel_valid; the next frame after 2500 low decodes normally.
REQ-040 Scenario: 12 bits, then 2500 low -> frame_done and err in the same cycle; frame_pixels=0; with the macro defined, frame_count=1 and err_count=1.
REQ-041 Scenario: rst_n low for 1 cycle during bit 10 of pixel 3 -> all outputs 0; no strobes until 2500 low cycles have passed.
